elastic_fifo: RTL and testbench
===============================

# elastic_fifo

Parametrised elastic buffer on a valid/ready stream. It stores up to DEPTH words, left-shifts each word by SHIFT on the output side, and reports its occupancy. It adds a synchronous flush. Both t0_ready and i0_valid are driven from registers only, so it breaks the combinational ready path between an upstream producer and a downstream consumer. It sits in the same stream positions as the single-stage elastic stage and replaces it wherever more slack or path isolation is needed.

## Interface
- DW, 32: data width, ≥1.
- DEPTH, 4: storage entries, power of 2, ≥2.
- SHIFT, 2: left-shift applied to output data, 0 ≤ SHIFT < DW.
- CW, $clog2(DEPTH+1): derived (localparam), count width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all stored words.
- t0_data  in  DW  upstream data.
- t0_valid  in  1  upstream valid.
- t0_ready  out  1  upstream ready (registered).
- i0_data  out  DW  downstream data, stored word << SHIFT, truncated to DW.
- i0_valid  out  1  downstream valid (registered state).
- i0_ready  in  1  downstream ready.
- count  out  CW  words currently stored, 0..DEPTH.

## Operation
- push = t0_valid & t0_ready; pop = i0_valid & i0_ready.
- Storage: DEPTH-entry array, wr_ptr and rd_ptr of log2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- count holds the occupancy:
  - count_next = count + push − pop.
  - full = (count == DEPTH); empty = (count == 0).
- On push: mem[wr_ptr] ← t0_data, then wr_ptr++.
- On pop: rd_ptr++.
- i0_valid = !empty.
- i0_data = (mem[rd_ptr] << SHIFT)[DW-1:0] when i0_valid, else 0. Upper bits shifted out are discarded.
- t0_ready register, next value:
  - 1 if flush;
  - else (count_next < DEPTH).
- No combinational path from any input to t0_ready, i0_valid or count. i0_data depends only on registered state.
- Flush: pointers and count go to 0 and t0_ready to 1 at the next edge. Flush overrides push and pop in the same cycle; a handshake in that cycle is dropped (data lost, upstream sees it as accepted).
- Simultaneous events:
  - Full with i0_ready=1: t0_ready is 0, so pop only. count becomes DEPTH−1 and t0_ready rises the next cycle.
  - Empty with t0_valid=1: i0_valid is 0, so push only. No same-cycle bypass.
  - Neither full nor empty, push and pop together: count unchanged, one word per cycle throughput.
- Data stability: while i0_valid=1 and i0_ready=0, i0_data holds constant.

## Timing
- Reset (rst=1, asynchronous, any time including mid-transfer):
  - t0_ready=0, i0_valid=0, i0_data=0, count=0.
  - Pointers are cleared; stored contents are don't-care.
- First rising edge with rst=0: t0_ready becomes 1. In the cycle immediately after deassertion, t0_ready is still 0.
- Latency: a word pushed at edge N appears on i0_valid/i0_data after edge N (one cycle), provided no older words are queued.
- Steady-state throughput: 1 word/cycle while 0 < count < DEPTH.
- The full-to-not-full transition costs no bubble on the output side. On the input side, t0_ready re-asserts the cycle after the pop that made room.
- count updates at the same edge as the push/pop it reflects.

## Test plan
- Reset and release: hold rst=1 for 3 cycles with t0_valid=1 → t0_ready=0, i0_valid=0, i0_data=0, count=0 throughout. t0_ready=1 from the first edge after release.
- Fill and drain (DW=32, DEPTH=4, SHIFT=2), i0_ready=0:
  - Push 0x1, 0x2, 0x3, 0x4 → count 1..4, then t0_ready=0 with 0x5 held off.
  - Raise i0_ready → outputs 0x4, 0x8, 0xC, 0x10 in order; 0x5 accepted the cycle after the first pop.
- Streaming: t0_valid=i0_ready=1 for 100 cycles with incrementing data → after a 1-cycle startup, one output per cycle equal to input<<2, count steady at 1.
- Truncation: push 0xC000_0001 → i0_data=0x0000_0004.
- Flush: with count=3, assert flush alongside a push and a pop → next cycle count=0, i0_valid=0, t0_ready=1. The flushed words and the same-cycle push never appear on i0.
- Random backpressure: random t0_valid/i0_ready for 10k cycles, checked against a queue model → output order and values match, count matches the model, and t0_ready/i0_valid are never 1 when full/empty respectively.

Source files
------------

// File: rtl/elastic_fifo.sv
// rtl/elastic_fifo.sv - registered-handshake FIFO with output left-shift, occupancy count and synchronous flush
module elastic_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    parameter  int SHIFT = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] t0_data,
    input  logic          t0_valid,
    output logic          t0_ready,
    output logic [DW-1:0] i0_data,
    output logic          i0_valid,
    input  logic          i0_ready,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          push, pop;
    logic [DW-1:0] head;

    assign push = t0_valid & ready_q;
    assign pop  = valid_q & i0_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        // Flush wins over any same-cycle handshake; an accepted push is dropped.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        ready_d = flush | (count_d < DEPTH_C);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset: nothing reads it until the pointers say it is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= t0_data;
    end

    assign head     = mem_q[rd_ptr_q];
    assign i0_data  = valid_q ? (head << SHIFT) : '0;
    assign i0_valid = valid_q;
    assign t0_ready = ready_q;
    assign count    = count_q;
endmodule

// File: tb/tb_elastic_fifo.sv
// tb/tb_elastic_fifo.sv - directed and randomized checks for elastic_fifo
module tb_elastic_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int SHIFT = 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] t0_data = '0;
    logic          t0_valid = 1'b0;
    logic          t0_ready;
    logic [DW-1:0] i0_data;
    logic          i0_valid;
    logic          i0_ready = 1'b0;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    elastic_fifo #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i0_data(i0_data), .i0_valid(i0_valid), .i0_ready(i0_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic        ready_m;
    logic        push_m, pop_m;

    initial begin
        // Reset held for 3 cycles with upstream valid
        t0_valid = 1'b1;
        t0_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_t0_ready", 32'(t0_ready), 32'd0);
            check("rst_i0_valid", 32'(i0_valid), 32'd0);
            check("rst_i0_data", i0_data, 32'd0);
            check("rst_count", 32'(count), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("rel_t0_ready_low", 32'(t0_ready), 32'd0);
        step();
        check("rel_t0_ready_high", 32'(t0_ready), 32'd1);
        check("rel_count", 32'(count), 32'd0);
        check("rel_i0_valid", 32'(i0_valid), 32'd0);

        // Fill with backpressure
        i0_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            t0_data = 32'(k);
            step();
            check("fill_count", 32'(count), 32'(k));
            check("fill_i0_valid", 32'(i0_valid), 32'd1);
            check("fill_i0_data", i0_data, 32'h4);
        end
        check("full_t0_ready", 32'(t0_ready), 32'd0);
        t0_data = 32'h5;
        step();
        check("held_count", 32'(count), 32'd4);
        check("held_t0_ready", 32'(t0_ready), 32'd0);
        check("held_i0_data", i0_data, 32'h4);

        // Drain; 0x5 enters the cycle after the first pop
        i0_ready = 1'b1;
        step();
        check("drain1_count", 32'(count), 32'd3);
        check("drain1_t0_ready", 32'(t0_ready), 32'd1);
        check("drain1_data", i0_data, 32'h8);
        step();
        check("drain2_count", 32'(count), 32'd3);
        check("drain2_data", i0_data, 32'hC);
        t0_valid = 1'b0;
        step();
        check("drain3_count", 32'(count), 32'd2);
        check("drain3_data", i0_data, 32'h10);
        step();
        check("drain4_count", 32'(count), 32'd1);
        check("drain4_data", i0_data, 32'h14);
        step();
        check("drain5_count", 32'(count), 32'd0);
        check("drain5_valid", 32'(i0_valid), 32'd0);
        check("drain5_data", i0_data, 32'd0);

        // Truncation of upper bits
        i0_ready = 1'b0;
        t0_valid = 1'b1;
        t0_data  = 32'hC000_0001;
        step();
        t0_valid = 1'b0;
        check("trunc_data", i0_data, 32'h4);
        i0_ready = 1'b1;
        step();
        check("trunc_pop_count", 32'(count), 32'd0);

        // Streaming at full rate
        t0_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            t0_data = 32'h100 + 32'(i);
            step();
            check("stream_data", i0_data, (32'h100 + 32'(i)) << 2);
            check("stream_count", 32'(count), 32'd1);
        end
        t0_valid = 1'b0;
        step();
        check("stream_end_count", 32'(count), 32'd0);

        // Flush with simultaneous push and pop
        i0_ready = 1'b0;
        t0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t0_data = 32'hA + 32'(k);
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush    = 1'b1;
        t0_data  = 32'hD;
        i0_ready = 1'b1;
        step();
        flush    = 1'b0;
        t0_valid = 1'b0;
        i0_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(i0_valid), 32'd0);
        check("flush_t0_ready", 32'(t0_ready), 32'd1);
        check("flush_data", i0_data, 32'd0);
        step();
        check("postflush_count", 32'(count), 32'd0);
        t0_valid = 1'b1;
        t0_data  = 32'hE;
        step();
        t0_valid = 1'b0;
        check("postflush_head", i0_data, 32'h38);
        check("postflush_count1", 32'(count), 32'd1);
        i0_ready = 1'b1;
        step();
        check("postflush_empty", 32'(count), 32'd0);

        // Random backpressure against a queue model
        ready_m = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            t0_valid = 1'($urandom_range(0, 1));
            i0_ready = 1'($urandom_range(0, 1));
            t0_data  = $urandom;
            push_m = t0_valid & ready_m;
            pop_m  = i0_ready & (q.size() != 0);
            if (push_m) q.push_back(t0_data);
            step();
            if (pop_m) void'(q.pop_front());
            ready_m = (q.size() < DEPTH);
            check("rnd_count", 32'(count), 32'(q.size()));
            check("rnd_t0_ready", 32'(t0_ready), 32'(ready_m));
            check("rnd_i0_valid", 32'(i0_valid), 32'(q.size() != 0));
            if (q.size() != 0) check("rnd_i0_data", i0_data, q[0] << SHIFT);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
